ssd_value_formatter: RTL and testbench
======================================

# ssd_value_formatter

Sequential formatter that sits directly upstream of the seven-segment decoders and the 4-digit display controller. It captures a 16-bit operand or result on a start pulse and converts it to four 4-bit digit codes, either as raw hex or as decimal via an iterative double-dabble shift/add-3 engine. It also produces a leading-zero blank mask and an overflow flag. Digit outputs stay stable between conversions, so the multiplexed display never shows partial results.

## Interface
Parameters:
- none; widths are fixed at 16-bit input and 4 digits.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- value  in  16  unsigned operand; sampled only when start is accepted.
- dec  in  1  format select, sampled with value: 0 = hex, 1 = decimal.
- start  in  1  request pulse; accepted only in IDLE.
- busy  out  1  high while a decimal conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- ovf  out  1  decimal result exceeds 9999; holds until the next commit.
- dig0, dig1, dig2, dig3  out  4 each  digit codes; dig0 is least significant and feeds the rightmost anode.
- blank  out  4  bit i = 1 means digit i is a leading zero that must be blanked; blank[0] is always 0.

## Operation
- The clock is one domain and the reset is asynchronous active-low, as already decided.
- States: IDLE, CONV.
- IDLE, start=1, dec=0 (hex path):
  - Commit dig3..dig0 = value[15:12], value[11:8], value[7:4], value[3:0].
  - ovf = 0.
  - Pulse done.
  - Remain in IDLE.
- IDLE, start=1, dec=1 (decimal path):
  - Load the shift register with value and clear a 20-bit BCD accumulator (5 digits).
  - Clear the iteration counter.
  - Go to CONV.
- CONV, each cycle:
  - Each BCD nibble ≥ 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Increment the 5-bit counter.
  - After the 16th shift, move to the commit cycle.
- Decimal commit:
  - If BCD digit 4 is 0: dig3..dig0 = BCD digits 3..0, ovf = 0.
  - Otherwise (value ≥ 10000): all digits = 4'hF, ovf = 1.
  - Pulse done, return to IDLE.
- blank is computed at commit from the committed digits:
  - blank[3] = (dig3 == 0).
  - blank[2] = blank[3] & (dig2 == 0).
  - blank[1] = blank[2] & (dig1 == 0).
  - blank[0] = 0.
  - On overflow, blank = 4'b0000.
- start while busy: ignored, not queued. value and dec changes during CONV have no effect.
- start asserted continuously in IDLE restarts a conversion on every acceptance opportunity. Each completion still produces exactly one done pulse.
- Outputs hold their last committed values indefinitely.

## Timing
- Reset values: dig0..dig3 = 0, blank = 4'b1110, busy = 0, done = 0, ovf = 0, state = IDLE, counter = 0.
- Hex path: start sampled at edge E0. New digits, blank and done=1 appear after E0 and are valid for exactly one cycle for done. busy stays 0. Latency is 1 clock.
- Decimal path, start sampled at E0:
  - busy = 1 from after E0 until E17.
  - Shifts occur at E1..E16.
  - Commit at E17: digits, blank and ovf update, done = 1 for the cycle after E17, busy = 0.
  - Latency is 17 clocks, start to done.
- Earliest next accept: the cycle in which done is high. A start there is sampled at E18.
- Reset asserted mid-conversion: all outputs go to reset values immediately. No done pulse is produced for the aborted request.
- Counter never wraps; CONV always exits after exactly 16 shifts.
- All outputs are registered; no combinational path from start or value to outputs.

## Test plan
- Reset, then release with no start -> digits 0,0,0,0, blank=1110, busy=0, done=0, ovf=0 for 50 cycles.
- Hex, value=16'hBEEF, dec=0 -> one cycle later dig3..dig0 = B,E,E,F, blank=0000, done high exactly 1 cycle, busy never high.
- Decimal 1234 -> busy high 17 cycles, then dig3..dig0 = 1,2,3,4, blank=0000, ovf=0, single done. Repeat with 9999 -> 9,9,9,9 and 0 -> 0,0,0,0 with blank=1110.
- Decimal 7, then decimal 305 -> first gives dig0=7, blank=1110; second gives 0,3,0,5 with blank=1000.
- Decimal 10000 and 65535 -> ovf=1, digits F,F,F,F, blank=0000. A following hex 16'h0012 -> ovf=0, blank=1100.
- start pulsed at cycles 5 and 10 of a decimal conversion of 42 -> exactly one done, result 0,0,4,2. Repeat with rst low at cycle 8 of the conversion -> outputs reset immediately and no done appears.

Source files
------------

// File: rtl/ssd_value_formatter.sv
// ssd_value_formatter
//   Captures a 16-bit value on a start pulse and turns it into four 4-bit
//   digit codes for the seven-segment path. Hex commits in one clock.
//   Decimal runs a 16-step double-dabble (add-3 then shift) and then commits
//   in one extra cycle. Committed outputs hold until the next commit, so the
//   display multiplexer never sees a partial result.
//
// Ports
//   clk    : system clock
//   rst    : asynchronous, active-low reset
//   value  : unsigned operand, sampled when start is accepted
//   dec    : format select sampled with value (0 = hex, 1 = decimal)
//   start  : request pulse, accepted only while idle
//   busy   : high while a decimal conversion is in progress
//   done   : one-cycle pulse when new digits are committed
//   ovf    : decimal value exceeded 9999; held until the next commit
//   dig0..dig3 : digit codes, dig0 least significant
//   blank  : bit i set = digit i is a leading zero (blank[0] always 0)
module ssd_value_formatter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        dec,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic [3:0]  blank
);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [15:0] bin;
  logic [19:0] bcd;

  logic        accept_dec;
  logic        last_step;
  logic        commit;
  logic [15:0] dig_nxt;
  logic [3:0]  blank_nxt;
  logic        ovf_nxt;

  // Add 3 to every BCD nibble that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [19:0] add3_all(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5)
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Leading-zero mask; the least significant digit is never blanked.
  function automatic logic [3:0] blank_of(input logic [15:0] d);
    logic b3, b2, b1;
    b3 = (d[15:12] == 4'd0);
    b2 = b3 & (d[11:8] == 4'd0);
    b1 = b2 & (d[7:4] == 4'd0);
    return {b3, b2, b1, 1'b0};
  endfunction

  assign accept_dec = (state == IDLE) && start && dec;
  // cnt reaches 16 after the 16th shift; the following cycle is the commit.
  assign last_step  = (state == CONV) && (cnt == 5'd16);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      if (accept_dec)
        cnt <= 5'd0;
      else if (state == CONV && !last_step)
        cnt <= cnt + 5'd1;
    end
  end

  // Shift/accumulate datapath; always loaded before use, so no reset.
  always_ff @(posedge clk) begin
    if (accept_dec) begin
      bin <= value;
      bcd <= 20'd0;
    end else if (state == CONV && !last_step) begin
      {bcd, bin} <= {add3_all(bcd), bin} << 1;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && dec) state_nxt = CONV;
      CONV: if (cnt == 5'd16) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output logic: values to commit on this edge ----
  always_comb begin
    commit    = 1'b0;
    dig_nxt   = {dig3, dig2, dig1, dig0};
    blank_nxt = blank;
    ovf_nxt   = ovf;
    if ((state == IDLE) && start && !dec) begin
      commit    = 1'b1;
      dig_nxt   = value;
      blank_nxt = blank_of(value);
      ovf_nxt   = 1'b0;
    end else if (last_step) begin
      commit = 1'b1;
      if (bcd[19:16] == 4'd0) begin
        dig_nxt   = bcd[15:0];
        blank_nxt = blank_of(bcd[15:0]);
        ovf_nxt   = 1'b0;
      end else begin
        dig_nxt   = 16'hFFFF;
        blank_nxt = 4'b0000;
        ovf_nxt   = 1'b1;
      end
    end
  end

  // ---- registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      dig0  <= 4'd0;
      dig1  <= 4'd0;
      dig2  <= 4'd0;
      dig3  <= 4'd0;
      blank <= 4'b1110;
    end else begin
      busy <= (state_nxt == CONV);
      done <= commit;
      if (commit) begin
        {dig3, dig2, dig1, dig0} <= dig_nxt;
        blank <= blank_nxt;
        ovf   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ssd_value_formatter.sv
module tb_ssd_value_formatter;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        dec;
  logic        start;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic [3:0]  blank;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ssd_value_formatter dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .dec   (dec),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .dig0  (dig0),
    .dig1  (dig1),
    .dig2  (dig2),
    .dig3  (dig3),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Packed view of every output: {busy, done, ovf, dig3..dig0, blank}
  function automatic logic [31:0] outs();
    return {9'd0, busy, done, ovf, dig3, dig2, dig1, dig0, blank};
  endfunction

  localparam logic [31:0] RESET_OUTS = {9'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1110};

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("digits", {16'd0, dig3, dig2, dig1, dig0}, {16'd0, e.dig});
        chk("blank",  {28'd0, blank}, {28'd0, e.blank});
        chk("ovf",    {31'd0, ovf},   {31'd0, e.ovf});
      end
    end
  end

  // Issue one request. xs1/xs2: cycles of the conversion with an extra
  // start pulse; rst_at: cycle at which reset aborts the request (0 = none).
  task automatic run(input logic [15:0] v, input logic d, input logic [15:0] edig,
                     input logic [3:0] eblank, input logic eovf,
                     input int xs1, input int xs2, input int rst_at);
    int lat;
    int bcnt;
    bit seen;
    exp_t e;
    lat = 0; bcnt = 0; seen = 0;
    e.dig = edig; e.blank = eblank; e.ovf = eovf;
    if (rst_at == 0) exp_q.push_back(e);
    @(posedge clk); #1;
    value = v; dec = d; start = 1'b1;
    @(posedge clk); #1;            // this edge is E0
    start = 1'b0;
    value = 16'($urandom);        // must not disturb a running conversion
    dec   = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == xs1 || k == xs2);
      if (k == rst_at) begin
        rst = 1'b0;
        #1;
        chk("reset_abort_outs", outs(), RESET_OUTS);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("after_abort_outs", outs(), RESET_OUTS);
        return;
      end
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    // Decimal: busy over E0..E17 (17 cycles), done in the cycle after E17,
    // i.e. the 18th negedge after E0. Hex: done in the cycle after E0.
    chk("done_latency", lat, d ? 32'd18 : 32'd1);
    chk("busy_cycles",  bcnt, d ? 32'd17 : 32'd0);
    @(negedge clk);
    chk("done_single", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; value = 16'd0; dec = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_held", outs(), RESET_OUTS);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_after_reset", outs(), RESET_OUTS);
    end

    run(16'hBEEF, 1'b0, 16'hBEEF, 4'b0000, 1'b0, 0, 0, 0);
    run(16'd1234, 1'b1, 16'h1234, 4'b0000, 1'b0, 0, 0, 0);
    run(16'd9999, 1'b1, 16'h9999, 4'b0000, 1'b0, 0, 0, 0);
    run(16'd0,    1'b1, 16'h0000, 4'b1110, 1'b0, 0, 0, 0);
    run(16'd7,    1'b1, 16'h0007, 4'b1110, 1'b0, 0, 0, 0);
    run(16'd305,  1'b1, 16'h0305, 4'b1000, 1'b0, 0, 0, 0);
    run(16'd10000, 1'b1, 16'hFFFF, 4'b0000, 1'b1, 0, 0, 0);
    run(16'd65535, 1'b1, 16'hFFFF, 4'b0000, 1'b1, 0, 0, 0);
    run(16'h0012, 1'b0, 16'h0012, 4'b1100, 1'b0, 0, 0, 0);
    run(16'd42,   1'b1, 16'h0042, 4'b1100, 1'b0, 5, 10, 0);
    run(16'd42,   1'b1, 16'h0042, 4'b1100, 1'b0, 5, 0, 8);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
